// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename-stage handshake bundle for the physical register free list
interface free_list_if #(
    parameter int PREG_W = 6
);
    logic              alloc_req;
    logic              alloc_valid;
    logic [PREG_W-1:0] alloc_preg;
    logic              commit_en;
    logic              release_en;
    logic [PREG_W-1:0] release_preg;
    logic              flush;
    logic [PREG_W-1:0] free_count;
    logic              err;

    modport master (
        output alloc_req, commit_en, release_en, release_preg, flush,
        input  alloc_valid, alloc_preg, free_count, err
    );

    modport slave (
        input  alloc_req, commit_en, release_en, release_preg, flush,
        output alloc_valid, alloc_preg, free_count, err
    );
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular physical register free list with speculative and committed heads
module free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32,
    parameter int PREG_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    free_list_if.slave fl
);
    localparam int DEPTH = NUM_PREG - NUM_AREG;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  specHead;
    logic [PTR_W-1:0]  commitHead;
    logic [PTR_W-1:0]  tail;
    logic              errQ;

    logic [PTR_W-1:0]  freeCnt;
    logic [PTR_W-1:0]  committedCnt;
    logic              allocFire;
    logic              commitLegal;
    logic              commitErr;
    logic              releaseReq;
    logic              releaseRoom;
    logic              releaseFire;
    logic              releaseErr;

    always_comb begin
        freeCnt      = tail - specHead;
        committedCnt = tail - commitHead;
        allocFire    = fl.alloc_req && (freeCnt != '0) && !fl.flush;
        commitLegal  = fl.commit_en && (commitHead != specHead);
        commitErr    = fl.commit_en && (commitHead == specHead);
        releaseReq   = fl.release_en && (fl.release_preg != '0);
        // A same-cycle commit frees the slot the release is about to write.
        releaseRoom  = (committedCnt != PTR_DEPTH) || commitLegal;
        releaseFire  = releaseReq && releaseRoom;
        releaseErr   = releaseReq && !releaseRoom;
    end

    assign fl.free_count  = PREG_W'(freeCnt);
    assign fl.alloc_valid = (freeCnt != '0);
    assign fl.alloc_preg  = mem[specHead[IDX_W-1:0]];
    assign fl.err         = errQ;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(NUM_AREG + i);
            end
            specHead   <= '0;
            commitHead <= '0;
            tail       <= PTR_DEPTH;
            errQ       <= 1'b0;
        end else begin
            if (releaseFire) begin
                mem[tail[IDX_W-1:0]] <= fl.release_preg;
                tail                 <= tail + PTR_ONE;
            end
            if (commitLegal) begin
                commitHead <= commitHead + PTR_ONE;
            end
            // Recovery rewinds to the committed point, including any commit retiring now.
            if (fl.flush) begin
                specHead <= commitLegal ? commitHead + PTR_ONE : commitHead;
            end else if (allocFire) begin
                specHead <= specHead + PTR_ONE;
            end
            if (commitErr || releaseErr) begin
                errQ <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed table, corner sequences and queue-model random run for free_list
module tb_free_list;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    free_list_if #(.PREG_W(6)) fl();
    free_list #(.NUM_PREG(64), .NUM_AREG(32), .PREG_W(6)) dut (
        .clk  (clk),
        .reset(reset),
        .fl   (fl)
    );

    int nVec = 0;
    int nMis = 0;

    typedef struct {
        logic       a, c, r;
        logic [5:0] t;
        logic       f;
        logic       ev;
        logic [5:0] ep, ec;
        logic       ee;
    } vec_t;
    vec_t tbl[12];

    // Reference: ordered committed free list plus count of speculative allocations.
    int freeQ[$];
    int held[$];
    int nSpec;
    int mErr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a, input logic c, input logic r, input logic [5:0] t, input logic f);
        fl.alloc_req    = a;
        fl.commit_en    = c;
        fl.release_en   = r;
        fl.release_preg = t;
        fl.flush        = f;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b0;
        drive(0, 0, 0, 6'd0, 0);
        tick;
        tick;
        reset = 1'b1;
    endtask

    function automatic vec_t mk(int a, int c, int r, int t, int f, int ev, int ep, int ec, int ee);
        vec_t v;
        v.a = a[0]; v.c = c[0]; v.r = r[0]; v.t = t[5:0]; v.f = f[0];
        v.ev = ev[0]; v.ep = ep[5:0]; v.ec = ec[5:0]; v.ee = ee[0];
        return v;
    endfunction

    task automatic modelReset;
        freeQ = {};
        held = {};
        for (int i = 0; i < 32; i++) freeQ.push_back(32 + i);
        for (int i = 1; i < 32; i++) held.push_back(i);
        nSpec = 0;
        mErr = 0;
    endtask

    task automatic modelStep(input int a, input int c, input int r, input int t, input int f);
        int allocOk, commitOk, relOk;
        allocOk  = a && ((freeQ.size() - nSpec) != 0) && !f;
        commitOk = c && (nSpec > 0);
        relOk    = r && (t != 0) && ((freeQ.size() - commitOk) < 32);
        if (c && nSpec == 0) mErr = 1;
        if (r && t != 0 && !relOk) mErr = 1;
        if (commitOk) begin
            held.push_back(freeQ.pop_front());
            nSpec--;
        end
        if (relOk) freeQ.push_back(t);
        if (f) nSpec = 0;
        else if (allocOk) nSpec++;
    endtask

    task automatic checkModel(input string tag);
        int cnt;
        cnt = freeQ.size() - nSpec;
        check({tag, "_count"}, 32'(fl.free_count), 32'(cnt));
        check({tag, "_valid"}, 32'(fl.alloc_valid), 32'(cnt != 0));
        check({tag, "_err"}, 32'(fl.err), 32'(mErr));
        if (cnt != 0) check({tag, "_preg"}, 32'(fl.alloc_preg), 32'(freeQ[nSpec]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 33, 31, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 1, 34, 30, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1, 35, 29, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 36, 28, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 1, 36, 28, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 1, 33, 31, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 1, 33, 31, 0);
        tbl[7]  = mk(1, 0, 0, 0, 1, 1, 33, 31, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 34, 30, 0);
        tbl[9]  = mk(1, 1, 0, 0, 1, 1, 34, 30, 0);
        tbl[10] = mk(0, 0, 1, 7, 0, 1, 34, 31, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, 35, 30, 0);

        drive(0, 0, 0, 6'd0, 0);
        @(negedge clk);
        doReset;
        check("rst_count", 32'(fl.free_count), 32);
        check("rst_valid", 32'(fl.alloc_valid), 1);
        check("rst_preg", 32'(fl.alloc_preg), 32);
        check("rst_err", 32'(fl.err), 0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a, tbl[i].c, tbl[i].r, tbl[i].t, tbl[i].f);
            tick;
            check($sformatf("tbl%0d_valid", i), 32'(fl.alloc_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_preg", i), 32'(fl.alloc_preg), 32'(tbl[i].ep));
            check($sformatf("tbl%0d_count", i), 32'(fl.free_count), 32'(tbl[i].ec));
            check($sformatf("tbl%0d_err", i), 32'(fl.err), 32'(tbl[i].ee));
        end

        // Reset overrides concurrent flush, alloc, commit and release.
        reset = 1'b0;
        drive(1, 1, 1, 6'd9, 1);
        tick;
        reset = 1'b1;
        drive(0, 0, 0, 6'd0, 0);
        check("rstflush_count", 32'(fl.free_count), 32);
        check("rstflush_preg", 32'(fl.alloc_preg), 32);
        check("rstflush_err", 32'(fl.err), 0);

        // Exhaust, stall, then commit+release refills with the returned tag.
        drive(1, 0, 0, 6'd0, 0);
        repeat (32) tick;
        check("empty_count", 32'(fl.free_count), 0);
        check("empty_valid", 32'(fl.alloc_valid), 0);
        tick;
        check("stall_count", 32'(fl.free_count), 0);
        check("stall_err", 32'(fl.err), 0);
        drive(0, 1, 1, 6'd5, 0);
        tick;
        check("refill_valid", 32'(fl.alloc_valid), 1);
        check("refill_preg", 32'(fl.alloc_preg), 5);
        check("refill_count", 32'(fl.free_count), 1);
        drive(0, 0, 1, 6'd0, 0);
        tick;
        check("p0_count", 32'(fl.free_count), 1);
        check("p0_preg", 32'(fl.alloc_preg), 5);
        check("p0_err", 32'(fl.err), 0);

        // Illegal commit sets a sticky error.
        doReset;
        drive(0, 1, 0, 6'd0, 0);
        tick;
        check("cerr_set", 32'(fl.err), 1);
        drive(0, 0, 0, 6'd0, 0);
        repeat (3) tick;
        check("cerr_sticky", 32'(fl.err), 1);

        // Release into a full committed list is dropped.
        doReset;
        check("rerr_clear", 32'(fl.err), 0);
        drive(0, 0, 1, 6'd9, 0);
        tick;
        check("rerr_set", 32'(fl.err), 1);
        check("rerr_count", 32'(fl.free_count), 32);
        check("rerr_preg", 32'(fl.alloc_preg), 32);

        // Random legal traffic across many pointer wraps.
        doReset;
        modelReset;
        for (int n = 0; n < 400; n++) begin
            int a, c, r, t, f, idx;
            a = int'($urandom_range(0, 1));
            c = (nSpec > 0) && ($urandom_range(0, 1) == 1);
            f = ($urandom_range(0, 15) == 0);
            r = 0;
            t = 0;
            if (held.size() > 0 && (freeQ.size() - c) < 32 && $urandom_range(0, 2) != 0) begin
                idx = int'($urandom_range(0, held.size() - 1));
                t = held[idx];
                held.delete(idx);
                r = 1;
            end else if ($urandom_range(0, 9) == 0) begin
                r = 1;
            end
            drive(a[0], c[0], r[0], t[5:0], f[0]);
            modelStep(a, c, r, t, f);
            tick;
            checkModel($sformatf("rnd%0d", n));
        end
        drive(0, 0, 0, 6'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter NUM_PREG, default 64, number of physical registers.
REQ-002 Parameter NUM_AREG, default 32, number of architectural registers; list depth is NUM_PREG-NUM_AREG (32).
REQ-003 Parameter PREG_W, default 6, physical register tag width.
REQ-004 Port clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous to clk, active-low (0 = reset).
REQ-006 Port alloc_req  input  1  rename stage requests one free physical register this cycle.
REQ-007 Port alloc_valid  output  1  a free register is available at alloc_preg.
REQ-008 Port alloc_preg  output  PREG_W  tag at speculative head; feeds the RAT new-dest write data.
REQ-009 Port commit_en  input  1  oldest in-flight allocation retires (commit head advances).
REQ-010 Port release_en  input  1  retiring instruction returns its old dest mapping.
REQ-011 Port release_preg  input  PREG_W  old physical tag read from the RAT at rename, returned at retire.
REQ-012 Port flush  input  1  mispredict recovery; discard all uncommitted allocations.
REQ-013 Port free_count  output  PREG_W  speculative free entries, 0..32.
REQ-014 Port err  output  1  sticky protocol-violation flag.

Function
REQ-015 Storage SHALL be a 32-entry circular buffer of PREG_W-bit tags with three 6-bit pointers (5-bit index + wrap bit): spec_head, commit_head, tail.
REQ-016 free_count SHALL equal tail - spec_head (modulo 64); alloc_valid SHALL be (free_count != 0); alloc_preg SHALL be mem[spec_head index], combinational from registered state.
REQ-017 Allocation SHALL fire when alloc_req && alloc_valid && !flush; spec_head increments at the next edge; alloc_req with alloc_valid=0 SHALL be ignored with no state change and no err.
REQ-018 Release SHALL write release_preg to mem[tail index] and increment tail; a tag released in cycle N SHALL NOT be visible on alloc_preg before cycle N+1 (no bypass).
REQ-019 release_preg == 0 SHALL be ignored (p0 permanently bound to x0); no write, no pointer change, no err.
REQ-020 Release when tail - commit_head == 32 (committed list full) SHALL be dropped and SHALL set err.
REQ-021 commit_en SHALL increment commit_head; commit_en when commit_head == spec_head (nothing uncommitted) SHALL be ignored and SHALL set err.
REQ-022 flush SHALL load spec_head with commit_head, or commit_head+1 if a legal commit_en fires in the same cycle; flush has priority over alloc_req.
REQ-023 Release and commit in the same cycle as flush SHALL still take effect.
REQ-024 Alloc, commit and release in one cycle SHALL all take effect independently; pointer wrap from index 31 to 0 SHALL toggle the wrap bit.
REQ-025 Single-cycle latency: outputs reflect every accepted operation at the next rising edge.

Reset
REQ-026 While reset=0 at a rising edge: mem[i] = 32+i for i=0..31, spec_head = commit_head = 0, tail = 6'b100000, err = 0.
REQ-027 After reset: free_count = 32, alloc_valid = 1, alloc_preg = 32; reset SHALL override all concurrent requests, including mid-flush.

Verification
REQ-028 Reset, then alloc_req for 3 cycles -> alloc_preg 32, 33, 34 on successive cycles; free_count 32 -> 29.
REQ-029 Alloc 32 times -> free_count 0, alloc_valid 0; further alloc_req leaves state unchanged, err stays 0.
REQ-030 Alloc 4 (tags 32..35), commit_en 1 cycle, flush -> spec_head = commit_head, alloc_preg = 33, free_count = 31.
REQ-031 Commit_en+release_en (preg 5) after 32 allocs -> next cycle alloc_valid 1, alloc_preg 5, free_count 1; release preg 0 -> no change.
REQ-032 commit_en with no outstanding allocation -> err = 1 next cycle, remains 1 until reset; release with tail - commit_head == 32 -> err = 1, tail unchanged.
REQ-033 Run 100 alloc/commit/release cycles across pointer wrap -> committed-list size stays 32, no tag duplicated, no tag lost.
